// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  // Stall vector is {wb,mem,ex,id,if,pc}; a set bit holds that stage's register.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam int unsigned MC_W_DEF   = 6;
  localparam int unsigned PERF_W_DEF = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the id/ex/redirect logic and the pipeline sequencing controller.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_W   = MC_W_DEF,
  parameter int unsigned PERF_W = PERF_W_DEF
) ();

  logic              stallreq_id;
  logic              ex_mc_start;
  logic [MC_W-1:0]   ex_mc_cycles;
  logic              flush_req;
  logic [5:0]        stall;
  logic              flush;
  logic              ex_mc_busy;
  logic              ex_mc_done;
  logic [PERF_W-1:0] stall_cnt;

  // Pipeline side: raises requests, consumes stall/flush.
  modport master (
    output stallreq_id, ex_mc_start, ex_mc_cycles, flush_req,
    input  stall, flush, ex_mc_busy, ex_mc_done, stall_cnt
  );

  // Controller side.
  modport slave (
    input  stallreq_id, ex_mc_start, ex_mc_cycles, flush_req,
    output stall, flush, ex_mc_busy, ex_mc_done, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_perf_sat_counter.sv
// Enable-driven saturating event counter; sticks at all-ones instead of wrapping.
module perf_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, holding once the maximum value is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges the ID load-use stall with multi-cycle
// EX occupancy, handles flush abort and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_W   = MC_W_DEF,
  parameter int unsigned PERF_W = PERF_W_DEF
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  state_t          state;
  state_t          state_nxt;
  logic [MC_W-1:0] cnt;
  logic [MC_W-1:0] cnt_nxt;

  logic            mc_start_ok;
  logic            ex_stall;
  logic [5:0]      stall_v;
  logic            flush_v;
  logic            busy_v;
  logic            done_v;
  logic            stall_any;

  // Ops of length 0 or 1 complete in a single EX cycle and never occupy the FSM.
  assign mc_start_ok = bus.ex_mc_start && (bus.ex_mc_cycles >= MC_W'(2));

  // State and occupancy counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: flush aborts any op and drops a coincident start.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.flush_req) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_start_ok) begin
            state_nxt = MC_BUSY;
            cnt_nxt   = bus.ex_mc_cycles - MC_W'(1);
          end
        end
        MC_BUSY: begin
          if (cnt > MC_W'(1)) begin
            cnt_nxt = cnt - MC_W'(1);
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs: combinational, all forced low during reset; flush overrides everything.
  always_comb begin
    ex_stall = 1'b0;
    stall_v  = STALL_NONE;
    flush_v  = 1'b0;
    busy_v   = 1'b0;
    done_v   = 1'b0;
    if (!rst) begin
      if (bus.flush_req) begin
        flush_v = 1'b1;
      end else begin
        case (state)
          IDLE: begin
            ex_stall = mc_start_ok;
            busy_v   = mc_start_ok;
          end
          MC_BUSY: begin
            busy_v   = 1'b1;
            done_v   = (cnt <= MC_W'(1));
            ex_stall = (cnt > MC_W'(1));
          end
          default: ;
        endcase
        if (ex_stall) begin
          stall_v = STALL_EX;
        end else if (bus.stallreq_id) begin
          stall_v = STALL_ID;
        end
      end
    end
  end

  assign stall_any      = (stall_v != STALL_NONE);
  assign bus.stall      = stall_v;
  assign bus.flush      = flush_v;
  assign bus.ex_mc_busy = busy_v;
  assign bus.ex_mc_done = done_v;

  perf_sat_counter #(
    .WIDTH(PERF_W)
  ) u_perf (
    .clk  (clk),
    .rst  (rst),
    .en   (stall_any),
    .count(bus.stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each step pushes its expected outputs, which
// are popped and compared mid-cycle once the DUT has settled.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic [5:0] stall;
    logic       flush;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic       id;
    logic       st;
    logic [5:0] n;
    logic       fl;
    obs_t       e;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_cnt = '0;
  obs_t        sb[$];

  pipe_ctrl_if #(.MC_W(6), .PERF_W(32)) bus ();
  pipe_ctrl_if #(.MC_W(6), .PERF_W(3))  bus_s ();

  pipe_ctrl #(.MC_W(6), .PERF_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pipe_ctrl #(.MC_W(6), .PERF_W(3)) dut_s (
    .clk(clk),
    .rst(rst),
    .bus(bus_s)
  );

  always #5 clk = ~clk;

  task automatic drive_step(input step_t s);
    bus.stallreq_id  = s.id;
    bus.ex_mc_start  = s.st;
    bus.ex_mc_cycles = s.n;
    bus.flush_req    = s.fl;
    sb.push_back(s.e);
  endtask

  task automatic test_reset();
    obs_t act;
    bus.stallreq_id  = 1'b1;
    bus.ex_mc_start  = 1'b1;
    bus.ex_mc_cycles = 6'd4;
    bus.flush_req    = 1'b1;
    #2;
    act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
    n_cmp++;
    if (act !== 9'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b", act, 9'd0);
    end
    n_cmp++;
    if (bus.stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt);
    end
    bus.stallreq_id = 1'b0;
    bus.ex_mc_start = 1'b0;
    bus.flush_req   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_mc_n4();
    step_t tbl[5];
    obs_t  e;
    obs_t  act;
    tbl = '{18'b0_1_000100_0_001111_0_1_0,
            18'b0_0_000000_0_001111_0_1_0,
            18'b0_0_000000_0_001111_0_1_0,
            18'b0_0_000000_0_000000_0_1_1,
            18'b0_0_000000_0_000000_0_0_0};
    foreach (tbl[i]) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL mc_n4 step %0d: got %b want %b", i, act, e);
      end
      n_cmp++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL mc_n4_cnt step %0d: got %0d want %0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall != STALL_NONE) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_cycle();
    step_t tbl[5];
    obs_t  e;
    obs_t  act;
    tbl = '{18'b0_1_000001_0_000000_0_0_0,
            18'b0_1_000000_0_000000_0_0_0,
            18'b1_1_000001_0_000111_0_0_0,
            18'b1_1_000000_0_000111_0_0_0,
            18'b0_0_000000_0_000000_0_0_0};
    foreach (tbl[i]) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL single_cycle step %0d: got %b want %b", i, act, e);
      end
      n_cmp++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL single_cycle_cnt step %0d: got %0d want %0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall != STALL_NONE) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // N=3 with the ID request held; a second start while busy must not reload.
  task automatic test_id_overlap();
    step_t tbl[5];
    obs_t  e;
    obs_t  act;
    tbl = '{18'b1_1_000011_0_001111_0_1_0,
            18'b1_1_000101_0_001111_0_1_0,
            18'b1_0_000000_0_000111_0_1_1,
            18'b1_0_000000_0_000111_0_0_0,
            18'b0_0_000000_0_000000_0_0_0};
    foreach (tbl[i]) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL id_overlap step %0d: got %b want %b", i, act, e);
      end
      n_cmp++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL id_overlap_cnt step %0d: got %0d want %0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall != STALL_NONE) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // Flush in the 2nd cycle of an N=6 op, then flush coinciding with a start in IDLE.
  task automatic test_flush();
    step_t tbl[6];
    obs_t  e;
    obs_t  act;
    tbl = '{18'b0_1_000110_0_001111_0_1_0,
            18'b1_1_000110_1_000000_1_0_0,
            18'b0_0_000000_0_000000_0_0_0,
            18'b0_1_000100_1_000000_1_0_0,
            18'b0_0_000000_0_000000_0_0_0,
            18'b1_0_000000_0_000111_0_0_0};
    foreach (tbl[i]) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL flush step %0d: got %b want %b", i, act, e);
      end
      n_cmp++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL flush_cnt step %0d: got %0d want %0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall != STALL_NONE) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // Shortest multi-cycle op back to back; the start during the done cycle is ignored.
  task automatic test_back_to_back();
    step_t tbl[5];
    obs_t  e;
    obs_t  act;
    tbl = '{18'b0_1_000010_0_001111_0_1_0,
            18'b0_1_000011_0_000000_0_1_1,
            18'b0_1_000010_0_001111_0_1_0,
            18'b0_0_000000_0_000000_0_1_1,
            18'b0_0_000000_0_000000_0_0_0};
    foreach (tbl[i]) begin
      drive_step(tbl[i]);
      @(negedge clk);
      e   = sb.pop_front();
      act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL back_to_back step %0d: got %b want %b", i, act, e);
      end
      n_cmp++;
      if (bus.stall_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL back_to_back_cnt step %0d: got %0d want %0d", i, bus.stall_cnt, exp_cnt);
      end
      if (e.stall != STALL_NONE) exp_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // Async reset in MC_BUSY with cnt=5: outputs and counter clear immediately.
  task automatic test_reset_mid_op();
    obs_t e;
    obs_t act;
    drive_step(18'b0_1_000110_0_001111_0_1_0);
    @(negedge clk);
    e   = sb.pop_front();
    act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL rst_mid_start: got %b want %b", act, e);
    end
    if (e.stall != STALL_NONE) exp_cnt++;
    @(posedge clk);
    #1;
    bus.ex_mc_start = 1'b0;
    bus.stallreq_id = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    exp_cnt = '0;
    act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
    n_cmp++;
    if (act !== 9'd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %b want %b", act, 9'd0);
    end
    n_cmp++;
    if (bus.stall_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL rst_mid_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // After release the FSM is IDLE, so only the ID stall shows.
    drive_step(18'b1_0_000000_0_000111_0_0_0);
    @(negedge clk);
    e   = sb.pop_front();
    act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL rst_mid_after: got %b want %b", act, e);
    end
    n_cmp++;
    if (bus.stall_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL rst_mid_after_cnt: got %0d want %0d", bus.stall_cnt, exp_cnt);
    end
    if (e.stall != STALL_NONE) exp_cnt++;
    @(posedge clk);
    #1;
    drive_step(18'b0_0_000000_0_000000_0_0_0);
    @(negedge clk);
    e   = sb.pop_front();
    act = {bus.stall, bus.flush, bus.ex_mc_busy, bus.ex_mc_done};
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL rst_mid_idle: got %b want %b", act, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Narrow instance: counter must climb to 7 and stay there.
  task automatic test_saturation();
    logic [2:0] want;
    bus_s.stallreq_id = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      want = (k < 7) ? 3'(k) : 3'd7;
      n_cmp++;
      if (bus_s.stall_cnt !== want) begin
        n_err++;
        $display("FAIL saturation k=%0d: got %0d want %0d", k, bus_s.stall_cnt, want);
      end
      @(posedge clk);
      #1;
    end
    bus_s.stallreq_id = 1'b0;
  endtask

  initial begin
    bus.stallreq_id    = 1'b0;
    bus.ex_mc_start    = 1'b0;
    bus.ex_mc_cycles   = '0;
    bus.flush_req      = 1'b0;
    bus_s.stallreq_id  = 1'b0;
    bus_s.ex_mc_start  = 1'b0;
    bus_s.ex_mc_cycles = '0;
    bus_s.flush_req    = 1'b0;

    test_reset();
    test_mc_n4();
    test_single_cycle();
    test_id_overlap();
    test_flush();
    test_back_to_back();
    test_reset_mid_op();
    test_saturation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
